// File: rtl/bus_ac_worker_if.sv
// Shared 16-bit register bus between the bus master and the autoclear worker.
// Signal names follow the worker's original port names.
interface bus_ac_worker_if;
  logic        i_Bus_CS;
  logic        i_Bus_Wr_Rd_n;
  logic [3:0]  i_Bus_Addr8;
  logic [15:0] i_Bus_Wr_Data;
  logic [15:0] o_Bus_Rd_Data;
  logic        o_Bus_Rd_DV;

  modport master (
    output i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr8, i_Bus_Wr_Data,
    input  o_Bus_Rd_Data, o_Bus_Rd_DV
  );

  modport slave (
    input  i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr8, i_Bus_Wr_Data,
    output o_Bus_Rd_Data, o_Bus_Rd_DV
  );
endinterface

// File: rtl/bus_ac_worker.sv
// Timed job engine downstream of the bus autoclear block: per-channel countdown
// jobs driven by start levels, with delay/status/counter registers on the bus.
module bus_ac_worker #(
  parameter int unsigned g_CHANNELS      = 2,
  parameter logic [15:0] g_DEFAULT_DELAY = 16'd10
) (
  input  logic                  i_Bus_Clk,
  input  logic                  i_Bus_Rst_L,
  bus_ac_worker_if.slave        bus_if,
  input  logic [g_CHANNELS-1:0] i_Start,
  output logic [g_CHANNELS-1:0] o_Done,
  output logic                  o_Busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q [g_CHANNELS];
  state_t      state_d [g_CHANNELS];
  logic [15:0] cnt_q   [g_CHANNELS];
  logic [15:0] cnt_d   [g_CHANNELS];
  logic [15:0] delay_q [g_CHANNELS];
  logic [15:0] delay_d [g_CHANNELS];
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_dv_q, rd_dv_d;

  logic [2:0]  word;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  done_inc;
  logic [2:0]  abort_inc;
  logic        unused_addr0;

  always_comb begin
    word  = bus_if.i_Bus_Addr8[3:1];
    wr_en = bus_if.i_Bus_CS & bus_if.i_Bus_Wr_Rd_n;
    rd_en = bus_if.i_Bus_CS & ~bus_if.i_Bus_Wr_Rd_n;
  end

  assign unused_addr0 = bus_if.i_Bus_Addr8[0];

  // Per-channel job FSM; completion/abort events are tallied for the counters.
  always_comb begin
    done_inc  = '0;
    abort_inc = '0;
    for (int unsigned n = 0; n < g_CHANNELS; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      case (state_q[n])
        ST_IDLE: begin
          if (i_Start[n]) begin
            state_d[n] = ST_RUN;
            cnt_d[n]   = delay_q[n];
          end
        end
        ST_RUN: begin
          if (!i_Start[n]) begin
            state_d[n] = ST_IDLE;
            abort_inc  = abort_inc + 3'd1;
          end else if (cnt_q[n] != '0) begin
            cnt_d[n] = cnt_q[n] - 16'd1;
          end else begin
            state_d[n] = ST_DONE;
            done_inc   = done_inc + 3'd1;
          end
        end
        ST_DONE: begin
          if (!i_Start[n]) state_d[n] = ST_IDLE;
        end
        default: state_d[n] = ST_IDLE;
      endcase
    end
  end

  // Clear is applied before this cycle's increment, so a simultaneous
  // clear and completion leaves the counter at the increment.
  always_comb begin
    for (int unsigned n = 0; n < g_CHANNELS; n++) begin
      delay_d[n] = delay_q[n];
      if (wr_en && (word == 3'(n))) delay_d[n] = bus_if.i_Bus_Wr_Data;
    end
    done_cnt_d  = ((wr_en && (word == 3'd7) && bus_if.i_Bus_Wr_Data[0]) ? '0 : done_cnt_q)
                  + 16'(done_inc);
    abort_cnt_d = ((wr_en && (word == 3'd7) && bus_if.i_Bus_Wr_Data[1]) ? '0 : abort_cnt_q)
                  + 16'(abort_inc);
  end

  always_comb begin
    rd_dv_d   = rd_en;
    rd_data_d = '0;
    if (rd_en) begin
      case (word)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          for (int unsigned n = 0; n < g_CHANNELS; n++) begin
            if (word == 3'(n)) rd_data_d = delay_q[n];
          end
        end
        3'd4: begin
          for (int unsigned n = 0; n < g_CHANNELS; n++) begin
            rd_data_d[n]     = (state_q[n] == ST_RUN);
            rd_data_d[8 + n] = (state_q[n] == ST_DONE);
          end
        end
        3'd5:    rd_data_d = done_cnt_q;
        3'd6:    rd_data_d = abort_cnt_q;
        default: rd_data_d = '0;
      endcase
    end
  end

  always_comb begin
    o_Done = '0;
    o_Busy = 1'b0;
    for (int unsigned n = 0; n < g_CHANNELS; n++) begin
      o_Done[n] = (state_q[n] == ST_DONE);
      o_Busy    = o_Busy | (state_q[n] == ST_RUN);
    end
  end

  assign bus_if.o_Bus_Rd_Data = rd_data_q;
  assign bus_if.o_Bus_Rd_DV   = rd_dv_q;

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      for (int unsigned n = 0; n < g_CHANNELS; n++) begin
        state_q[n] <= ST_IDLE;
        cnt_q[n]   <= '0;
        delay_q[n] <= g_DEFAULT_DELAY;
      end
      done_cnt_q  <= '0;
      abort_cnt_q <= '0;
      rd_data_q   <= '0;
      rd_dv_q     <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < g_CHANNELS; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
        delay_q[n] <= delay_d[n];
      end
      done_cnt_q  <= done_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_dv_q     <= rd_dv_d;
    end
  end

endmodule

// File: tb/tb_bus_ac_worker.sv
// Randomised scoreboard bench for bus_ac_worker; the reference model tracks how
// long each start level has been held and derives job state from that.
module tb_bus_ac_worker;
  localparam int          CH  = 2;
  localparam logic [15:0] DEF = 16'd10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] start;
  logic [CH-1:0] done;
  logic          busy;

  bus_ac_worker_if bus();

  bus_ac_worker #(.g_CHANNELS(CH), .g_DEFAULT_DELAY(DEF)) dut (
    .i_Bus_Clk   (clk),
    .i_Bus_Rst_L (rst_n),
    .bus_if      (bus.slave),
    .i_Start     (start),
    .o_Done      (done),
    .o_Busy      (busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          run_len [CH];
  int          jd      [CH];
  logic [15:0] dly     [4];
  logic [15:0] dcnt, acnt;
  logic [15:0] sb [$];

  // A job is running while its start level has been held for 1..delay+1 edges
  // and is done once held for delay+2 or more edges.
  function automatic bit m_running(input int n);
    return (run_len[n] >= 1) && (run_len[n] <= jd[n] + 1);
  endfunction

  function automatic bit m_done(input int n);
    return run_len[n] >= jd[n] + 2;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    logic [15:0] r;
    int w;
    r = '0;
    w = int'(a[3:1]);
    if (w < 4) begin
      if (w < CH) r = dly[w];
    end else if (w == 4) begin
      for (int n = 0; n < CH; n++) begin
        r[n]     = m_running(n);
        r[8 + n] = m_done(n);
      end
    end else if (w == 5) r = dcnt;
    else if (w == 6) r = acnt;
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int n = 0; n < CH; n++) begin
          run_len[n] = 0;
          jd[n]      = 0;
        end
        for (int n = 0; n < 4; n++) dly[n] = DEF;
        dcnt = '0;
        acnt = '0;
        sb.delete();
      end else begin
        int dinc;
        int ainc;
        int w;
        dinc = 0;
        ainc = 0;
        w    = int'(bus.i_Bus_Addr8[3:1]);
        if (bus.i_Bus_CS && !bus.i_Bus_Wr_Rd_n) sb.push_back(m_read(bus.i_Bus_Addr8));
        for (int n = 0; n < CH; n++) begin
          if (start[n]) begin
            if (run_len[n] == 0) jd[n] = int'(dly[n]);
            run_len[n]++;
            if (run_len[n] == jd[n] + 2) dinc++;
          end else begin
            if (m_running(n)) ainc++;
            run_len[n] = 0;
          end
        end
        if (bus.i_Bus_CS && bus.i_Bus_Wr_Rd_n) begin
          if (w == 7 && bus.i_Bus_Wr_Data[0]) dcnt = '0;
          if (w == 7 && bus.i_Bus_Wr_Data[1]) acnt = '0;
          if (w < CH) dly[w] = bus.i_Bus_Wr_Data;
        end
        dcnt = dcnt + 16'(dinc);
        acnt = acnt + 16'(ainc);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [CH-1:0] exp_done;
        logic          exp_busy;
        logic [15:0]   exp_rd;
        exp_busy = 1'b0;
        for (int n = 0; n < CH; n++) begin
          exp_done[n] = m_done(n);
          exp_busy    = exp_busy | m_running(n);
        end
        checks++;
        if (done !== exp_done) begin
          errors++;
          $display("FAIL o_Done @%0t: got %b expected %b", $time, done, exp_done);
        end
        checks++;
        if (busy !== exp_busy) begin
          errors++;
          $display("FAIL o_Busy @%0t: got %b expected %b", $time, busy, exp_busy);
        end
        if (bus.o_Bus_Rd_DV === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL rd_dv_unexpected @%0t: got DV=1 expected DV=0", $time);
          end else begin
            exp_rd = sb.pop_front();
            if (bus.o_Bus_Rd_Data !== exp_rd) begin
              errors++;
              $display("FAIL rd_data @%0t: got %h expected %h", $time, bus.o_Bus_Rd_Data, exp_rd);
            end
          end
        end else if (sb.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL rd_dv_missing @%0t: got DV=%b expected DV=1", $time, bus.o_Bus_Rd_DV);
          sb.delete();
        end
      end
    end
  end

  task automatic acc(input logic wr, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.i_Bus_CS      = 1'b1;
    bus.i_Bus_Wr_Rd_n = wr;
    bus.i_Bus_Addr8   = a;
    bus.i_Bus_Wr_Data = d;
  endtask

  task automatic rd(input logic [3:0] a);
    acc(1'b0, a, 16'h0000);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    acc(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_Bus_CS = 1'b0;
    end
  endtask

  task automatic st(input logic [CH-1:0] v);
    @(negedge clk);
    bus.i_Bus_CS = 1'b0;
    start        = v;
  endtask

  task automatic chk_now(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_now("async_done_drop", |done, 1'b0);
    chk_now("async_busy_drop", busy, 1'b0);
    @(negedge clk);
    start        = '0;
    bus.i_Bus_CS = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_Bus_CS      = 1'b0;
    bus.i_Bus_Wr_Rd_n = 1'b0;
    bus.i_Bus_Addr8   = '0;
    bus.i_Bus_Wr_Data = '0;
    start             = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd(4'h0); rd(4'h8); rd(4'hA); idle(2);

    wr(4'h0, 16'd5); st(2'b01); idle(10); st(2'b00); idle(2); rd(4'hA); idle(1);

    wr(4'h2, 16'd20); st(2'b10); idle(7); st(2'b00); idle(2);
    rd(4'h8); rd(4'hC); idle(1);

    wr(4'h0, 16'd3); wr(4'h2, 16'd3); st(2'b11); idle(6); st(2'b00); idle(1);
    rd(4'hA); wr(4'hE, 16'h0003); rd(4'hA); rd(4'hC); idle(1);

    wr(4'h0, 16'd0); st(2'b01); idle(3); wr(4'h0, 16'd50); st(2'b00); st(2'b01);
    idle(30); wr(4'h2, 16'd1); rd(4'h8); idle(25); st(2'b00); idle(2);

    wr(4'h0, 16'd2); st(2'b01); idle(2); wr(4'hE, 16'h0001); rd(4'hA); st(2'b00); idle(1);

    rd(4'h6); rd(4'hF); rd(4'h7); wr(4'h8, 16'hFFFF); wr(4'hA, 16'h1234); rd(4'h8); rd(4'hA);
    rd(4'hE); idle(2);

    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      logic [3:0]  a;
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        int unsigned b;
        b = $urandom_range(0, CH - 1);
        start[b] = ~start[b];
      end
      r = $urandom_range(0, 3);
      a = 4'($urandom_range(0, 15));
      if (r == 0) begin
        bus.i_Bus_CS = 1'b1; bus.i_Bus_Wr_Rd_n = 1'b0; bus.i_Bus_Addr8 = a;
      end else if (r == 1) begin
        bus.i_Bus_CS = 1'b1; bus.i_Bus_Wr_Rd_n = 1'b1; bus.i_Bus_Addr8 = a;
        bus.i_Bus_Wr_Data = (a < 4'h8) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      end else begin
        bus.i_Bus_CS = 1'b0;
      end
    end
    st(2'b00); idle(3);

    wr(4'h0, 16'd30); st(2'b01); idle(5);
    reset_pulse();
    rd(4'hC); rd(4'h0); idle(1);
    wr(4'h0, 16'd1); st(2'b01); idle(4);
    reset_pulse();
    rd(4'hC); rd(4'hA); rd(4'h8); idle(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
